// File: rtl/apb_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_bus_arbiter_if
//  Purpose  : Requester-side and APB-side signal bundle for apb_bus_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_bus_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
);
   // Local requester side
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      rsp_err;

   // APB side
   logic                      psel;
   logic                      penable;
   logic [ADDR_W-1:0]         paddr;
   logic                      pwrite;
   logic [DATA_W-1:0]         pwdata;
   logic [DATA_W-1:0]         prdata;
   logic                      pready;
   logic                      pslverr;

   // Arbiter view
   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      input  prdata, pready, pslverr,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output psel, penable, paddr, pwrite, pwdata
   );

   // Requesters plus APB slave view
   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      output prdata, pready, pslverr,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  psel, penable, paddr, pwrite, pwdata
   );
endinterface
`default_nettype wire

// File: rtl/apb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_bus_arbiter
//  Purpose  : Round-robin sharing of one APB slave among NUM_REQ requesters.
//             Optional ACCESS-phase abort enabled by macro APB_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_bus_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  wire                clk,
   input  wire                reset_n,
   apb_bus_arbiter_if.master  bus
);

   localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t               state_q,     state_d;
   logic [c_PTR_W-1:0]   ptr_q,       ptr_d;
   logic [c_PTR_W-1:0]   win_q,       win_d;
   logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q,   rsp_err_d;
   logic                 psel_q,      psel_d;
   logic                 penable_q,   penable_d;
   logic [ADDR_W-1:0]    paddr_q,     paddr_d;
   logic                 pwrite_q,    pwrite_d;
   logic [DATA_W-1:0]    pwdata_q,    pwdata_d;

`ifdef APB_ARB_TIMEOUT_EN
   logic [7:0]           cnt_q,       cnt_d;
`else
   logic                 w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

   logic                 w_grant_vld;
   logic [c_PTR_W-1:0]   w_grant_idx;

   // First pending requester strictly after the last winner, wrapping around.
   always_comb begin : arb_search
      int idx;
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      idx         = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!w_grant_vld && bus.req_valid[c_PTR_W'(idx)]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = c_PTR_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= c_PTR_W'(NUM_REQ - 1);
         win_q       <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   always_comb begin : fsm_next
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (w_grant_vld) begin
               win_d                    = w_grant_idx;
               ptr_d                    = w_grant_idx;
               paddr_d                  = bus.req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
               pwdata_d                 = bus.req_wdata[int'(w_grant_idx)*DATA_W +: DATA_W];
               pwrite_d                 = bus.req_write[w_grant_idx];
               req_ready_d[w_grant_idx] = 1'b1;
               psel_d                   = 1'b1;
               penable_d                = 1'b0;
               state_d                  = ST_SETUP;
            end
         end

         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end

         ST_ACCESS: begin
            // A ready on the final timeout cycle still completes normally.
            if (bus.pready) begin
               psel_d             = 1'b0;
               penable_d          = 1'b0;
               rsp_valid_d[win_q] = 1'b1;
               rsp_rdata_d        = pwrite_q ? '0 : bus.prdata;
               rsp_err_d          = bus.pslverr;
               state_d            = ST_IDLE;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
               psel_d             = 1'b0;
               penable_d          = 1'b0;
               rsp_valid_d[win_q] = 1'b1;
               rsp_rdata_d        = '0;
               rsp_err_d          = 1'b1;
               state_d            = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end

         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.pwdata    = pwdata_q;

endmodule
`default_nettype wire
